// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared state type, constants and region decode for the I/O router
package io_bus_pkg;

  localparam int          REGION_W  = 6;
  localparam logic [15:0] ERR_RDATA = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Result of a region decode: hit=0 means no channel owns the region.
  typedef struct packed {
    logic       hit;
    logic [7:0] idx;
  } ch_sel_t;

  // Region 0 is reserved; region k (1..n_ch) maps to channel k-1.
  function automatic ch_sel_t decode_region(input logic [31:0] region, input logic [31:0] n_ch);
    ch_sel_t r;
    r.hit = (region != 32'd0) && (region <= n_ch);
    r.idx = r.hit ? 8'(region - 32'd1) : 8'd0;
    return r;
  endfunction

endpackage

// File: rtl/io_byte_lane.sv
// rtl/io_byte_lane.sv - byte-lane replication/mask for writes and lane extraction for reads
module io_byte_lane (
  input  logic        wr_byte,
  input  logic        wr_lane,
  input  logic [15:0] wr_data,
  output logic [15:0] wr_lane_data,
  output logic [1:0]  wr_mask,
  input  logic        rd_byte,
  input  logic        rd_lane,
  input  logic [15:0] rd_data,
  output logic [15:0] rd_lane_data
);

  // Byte writes put the byte on both lanes so the peripheral can pick either; mask names the lane.
  always_comb begin
    wr_lane_data = wr_data;
    wr_mask      = 2'b11;
    if (wr_byte) begin
      wr_lane_data = {wr_data[7:0], wr_data[7:0]};
      wr_mask      = wr_lane ? 2'b10 : 2'b01;
    end
  end

  // Byte reads return the addressed lane zero-extended into the low byte.
  always_comb begin
    rd_lane_data = rd_data;
    if (rd_byte) begin
      rd_lane_data = rd_lane ? {8'h00, rd_data[15:8]} : {8'h00, rd_data[7:0]};
    end
  end

endmodule

// File: rtl/io_bus_router.sv
// rtl/io_bus_router.sv - region-decoded single-outstanding router onto valid/ready peripheral channels
module io_bus_router
  import io_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int SEL_W   = REGION_W,
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     main_clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic                     req_byte,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [15:0]              req_wdata,
  output logic                     rsp_valid,
  output logic [15:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [N_CH-1:0]          ch_valid,
  input  logic [N_CH-1:0]          ch_ready,
  output logic                     ch_write,
  output logic [ADDR_W-SEL_W-1:0]  ch_addr,
  output logic [15:0]              ch_wdata,
  output logic [1:0]               ch_wmask,
  input  logic [N_CH-1:0]          ch_rvalid,
  input  logic [16*N_CH-1:0]       ch_rdata
);

  localparam int               CA_W     = ADDR_W - SEL_W;
  localparam int               CH_IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t                state_q, state_d;
  logic                  byte_q, byte_d;
  logic                  lane_q, lane_d;
  logic [CH_IDX_W-1:0]   ch_idx_q, ch_idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_CH-1:0]       ch_valid_q, ch_valid_d;
  logic                  ch_write_q, ch_write_d;
  logic [CA_W-1:0]       ch_addr_q, ch_addr_d;
  logic [15:0]           ch_wdata_q, ch_wdata_d;
  logic [1:0]            ch_wmask_q, ch_wmask_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [15:0]           rsp_rdata_q, rsp_rdata_d;

  ch_sel_t               req_sel;
  logic [N_CH-1:0]       req_onehot;
  logic                  ch_hs;
  logic                  rd_hit;
  logic [15:0]           rd_sel_data;
  logic                  timed_out;
  logic [15:0]           wr_lane_data;
  logic [1:0]            wr_mask;
  logic [15:0]           rd_lane_data;

  assign req_sel   = decode_region(32'(req_addr[ADDR_W-1 -: SEL_W]), 32'(N_CH));
  assign ch_hs     = |(ch_valid_q & ch_ready);
  assign timed_out = (cnt_q == CNT_MAX);

  io_byte_lane u_byte_lane (
    .wr_byte      (req_byte),
    .wr_lane      (req_addr[0]),
    .wr_data      (req_wdata),
    .wr_lane_data (wr_lane_data),
    .wr_mask      (wr_mask),
    .rd_byte      (byte_q),
    .rd_lane      (lane_q),
    .rd_data      (rd_sel_data),
    .rd_lane_data (rd_lane_data)
  );

  // One-hot strobe for the channel the incoming request decodes to.
  always_comb begin
    req_onehot = '0;
    for (int k = 0; k < N_CH; k++) begin
      req_onehot[k] = (req_sel.idx == 8'(k));
    end
  end

  // Pick the latched channel's read strobe and data; other channels are ignored.
  always_comb begin
    rd_sel_data = '0;
    rd_hit      = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_idx_q == CH_IDX_W'(k)) begin
        rd_sel_data = ch_rdata[16*k +: 16];
        rd_hit      = ch_rvalid[k];
      end
    end
  end

  // State register.
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a handshake beats a timeout on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = req_sel.hit ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        if (ch_hs)          state_d = ch_write_q ? ST_RESP : ST_WAIT_RD;
        else if (timed_out) state_d = ST_RESP;
      end
      ST_WAIT_RD: begin
        if (rd_hit || timed_out) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and latch updates; ch_valid drops the cycle the counter reaches TIMEOUT.
  always_comb begin
    byte_d      = byte_q;
    lane_d      = lane_q;
    ch_idx_d    = ch_idx_q;
    cnt_d       = cnt_q;
    ch_valid_d  = ch_valid_q;
    ch_write_d  = ch_write_q;
    ch_addr_d   = ch_addr_q;
    ch_wdata_d  = ch_wdata_q;
    ch_wmask_d  = ch_wmask_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = ERR_RDATA;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          byte_d     = req_byte;
          lane_d     = req_addr[0];
          ch_idx_d   = CH_IDX_W'(req_sel.idx);
          ch_write_d = req_write;
          ch_addr_d  = req_addr[CA_W-1:0];
          ch_wdata_d = wr_lane_data;
          ch_wmask_d = wr_mask;
          cnt_d      = '0;
          if (req_sel.hit) begin
            ch_valid_d = req_onehot;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (ch_hs) begin
          ch_valid_d  = '0;
          cnt_d       = '0;
          rsp_valid_d = ch_write_q;
        end else if (timed_out) begin
          ch_valid_d  = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((cnt_q + CNT_W'(1)) == CNT_MAX) ch_valid_d = '0;
        end
      end
      ST_WAIT_RD: begin
        if (rd_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_lane_data;
        end else if (timed_out) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Transaction latches, wait counter and registered outputs.
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      byte_q      <= 1'b0;
      lane_q      <= 1'b0;
      ch_idx_q    <= '0;
      cnt_q       <= '0;
      ch_valid_q  <= '0;
      ch_write_q  <= 1'b0;
      ch_addr_q   <= '0;
      ch_wdata_q  <= '0;
      ch_wmask_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      byte_q      <= byte_d;
      lane_q      <= lane_d;
      ch_idx_q    <= ch_idx_d;
      cnt_q       <= cnt_d;
      ch_valid_q  <= ch_valid_d;
      ch_write_q  <= ch_write_d;
      ch_addr_q   <= ch_addr_d;
      ch_wdata_q  <= ch_wdata_d;
      ch_wmask_q  <= ch_wmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ch_valid  = ch_valid_q;
  assign ch_write  = ch_write_q;
  assign ch_addr   = ch_addr_q;
  assign ch_wdata  = ch_wdata_q;
  assign ch_wmask  = ch_wmask_q;

endmodule

// File: tb/tb_io_bus_router.sv
// tb/tb_io_bus_router.sv - self-checking bench for io_bus_router
module tb_io_bus_router;

  localparam int NCH   = 4;
  localparam int TO    = 8;
  localparam int LIMIT = 100;

  logic        main_clk, reset;
  logic        req_valid, req_ready, req_write, req_byte;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [3:0]  ch_valid, ch_ready, ch_rvalid;
  logic        ch_write;
  logic [25:0] ch_addr;
  logic [15:0] ch_wdata;
  logic [1:0]  ch_wmask;
  logic [63:0] ch_rdata;

  int checks = 0;
  int errors = 0;
  logic noise;

  typedef struct {
    logic        w;
    logic        b;
    logic [31:0] a;
    logic [15:0] wd;
    int          d;
    int          r;
    logic [15:0] rd;
    int          lat;
    logic        err;
    logic [15:0] rdata;
    logic [3:0]  vmask;
    logic [15:0] xwd;
    logic [1:0]  xwm;
    int          vcyc;
  } vec_t;

  vec_t tbl[15];

  io_bus_router #(.ADDR_W(32), .SEL_W(6), .N_CH(NCH), .TIMEOUT(TO)) dut (
    .main_clk  (main_clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .ch_write  (ch_write),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_wmask  (ch_wmask),
    .ch_rvalid (ch_rvalid),
    .ch_rdata  (ch_rdata)
  );

  initial begin
    main_clk = 1'b0;
    forever #5 main_clk = ~main_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    check({p, " req_ready"}, 32'(req_ready), 32'd1);
    check({p, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({p, " rsp_err"},   32'(rsp_err),   32'd0);
    check({p, " rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({p, " ch_valid"},  32'(ch_valid),  32'd0);
    check({p, " ch_write"},  32'(ch_write),  32'd0);
    check({p, " ch_addr"},   32'(ch_addr),   32'd0);
    check({p, " ch_wdata"},  32'(ch_wdata),  32'd0);
    check({p, " ch_wmask"},  32'(ch_wmask),  32'd0);
  endtask

  // Reference: response timing and content straight from the protocol rules.
  function automatic vec_t model(input vec_t v);
    vec_t m = v;
    int region = int'(v.a[31:26]);
    m.xwd = v.b ? {v.wd[7:0], v.wd[7:0]} : v.wd;
    m.xwm = !v.b ? 2'b11 : (v.a[0] ? 2'b10 : 2'b01);
    if (region == 0 || region > NCH) begin
      m.lat = 1; m.err = 1'b1; m.rdata = 16'h0; m.vmask = 4'h0; m.vcyc = 0;
      return m;
    end
    m.vmask = 4'(1 << (region - 1));
    if (v.d >= TO) begin
      m.lat = TO + 2; m.err = 1'b1; m.rdata = 16'h0; m.vcyc = TO;
    end else begin
      m.vcyc = v.d + 1;
      if (v.w) begin
        m.lat = v.d + 2; m.err = 1'b0; m.rdata = 16'h0;
      end else if (v.r <= TO) begin
        m.lat = v.d + 3 + v.r; m.err = 1'b0;
        m.rdata = !v.b ? v.rd : (v.a[0] ? {8'h00, v.rd[15:8]} : {8'h00, v.rd[7:0]});
      end else begin
        m.lat = v.d + 3 + TO; m.err = 1'b1; m.rdata = 16'h0;
      end
    end
    return m;
  endfunction

  // Drives one request plus a peripheral that answers after d (ready) and r (rvalid) cycles.
  task automatic run_vec(input vec_t v, input int idx);
    int          region, sel, lat, vcyc;
    logic        err, after_valid, after_ready;
    logic [15:0] rdata, swd;
    logic [1:0]  swm;
    logic [25:0] sad;
    logic [3:0]  vmask;
    logic [63:0] bus;
    string       t;
    region = int'(v.a[31:26]);
    sel = (region >= 1 && region <= NCH) ? region - 1 : -1;
    lat = -1; vcyc = 0; err = 0; rdata = 0; swd = 0; swm = 0; sad = 0; vmask = 0;
    after_valid = 1'b1; after_ready = 1'b0;
    @(posedge main_clk); #1;
    req_valid = 1'b1; req_write = v.w; req_byte = v.b; req_addr = v.a; req_wdata = v.wd;
    ch_ready = 4'h0; ch_rvalid = 4'h0;
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge main_clk);
      if (c == 1) req_valid = 1'b0;
      if (lat >= 0) begin
        after_valid = rsp_valid; after_ready = req_ready;
        break;
      end
      if (|ch_valid) begin
        if (vcyc == 0) begin swd = ch_wdata; swm = ch_wmask; sad = ch_addr; end
        vcyc++;
        vmask = vmask | ch_valid;
      end
      if (rsp_valid) begin lat = c; err = rsp_err; rdata = rsp_rdata; end
      ch_ready  = noise ? 4'($urandom) : 4'h0;
      ch_rvalid = noise ? 4'($urandom) : 4'h0;
      for (int k = 0; k < NCH; k++) begin
        bus[16*k +: 16] = (k == sel) ? v.rd : 16'($urandom);
        if (k == sel) begin
          ch_ready[k]  = (c == 1 + v.d);
          ch_rvalid[k] = (c == 2 + v.d + v.r) || (noise && c == 1);
        end
      end
      ch_rdata = bus;
    end
    ch_ready = 4'h0; ch_rvalid = 4'h0;
    t = $sformatf("v%0d", idx);
    check({t, " latency"},   32'(lat),   32'(v.lat));
    check({t, " err"},       32'(err),   32'(v.err));
    check({t, " rdata"},     32'(rdata), 32'(v.rdata));
    check({t, " ch_valid"},  32'(vmask), 32'(v.vmask));
    check({t, " vcycles"},   32'(vcyc),  32'(v.vcyc));
    check({t, " one-pulse"}, 32'(after_valid), 32'd0);
    check({t, " ready-after"}, 32'(after_ready), 32'd1);
    if (v.vcyc > 0) check({t, " ch_addr"}, 32'(sad), 32'(v.a[25:0]));
    if (v.vcyc > 0 && v.w) begin
      check({t, " ch_wdata"}, 32'(swd), 32'(v.xwd));
      check({t, " ch_wmask"}, 32'(swm), 32'(v.xwm));
    end
  endtask

  initial begin
    logic seen;
    int   rg;
    vec_t v;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = 32'h0; req_wdata = 16'h0; ch_ready = 4'h0; ch_rvalid = 4'h0; ch_rdata = 64'h0;
    noise = 1'b0;
    //          w     b     addr          wd        d   r  rd        lat err   rdata     vmask   xwd       xwm    vcyc
    tbl[0]  = '{1'b0, 1'b0, 32'h0400_0010, 16'h0000, 0,  0, 16'hBEEF, 3,  1'b0, 16'hBEEF, 4'b0001, 16'h0000, 2'b11, 1};
    tbl[1]  = '{1'b1, 1'b1, 32'h0400_0003, 16'h12A5, 0,  0, 16'h0000, 2,  1'b0, 16'h0000, 4'b0001, 16'hA5A5, 2'b10, 1};
    tbl[2]  = '{1'b0, 1'b1, 32'h0800_0101, 16'h0000, 0,  0, 16'h3C7E, 3,  1'b0, 16'h003C, 4'b0010, 16'h0000, 2'b10, 1};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C00_0100, 16'h0000, 1,  2, 16'h3C7E, 6,  1'b0, 16'h007E, 4'b0100, 16'h0000, 2'b01, 2};
    tbl[4]  = '{1'b1, 1'b0, 32'h1000_0ABC, 16'h1234, 3,  0, 16'h0000, 5,  1'b0, 16'h0000, 4'b1000, 16'h1234, 2'b11, 4};
    tbl[5]  = '{1'b1, 1'b1, 32'h0800_0000, 16'h5A77, 0,  0, 16'h0000, 2,  1'b0, 16'h0000, 4'b0010, 16'h7777, 2'b01, 1};
    tbl[6]  = '{1'b0, 1'b0, 32'h0000_1234, 16'h0000, 0,  0, 16'h9999, 1,  1'b1, 16'h0000, 4'b0000, 16'h0000, 2'b11, 0};
    tbl[7]  = '{1'b0, 1'b0, 32'h1400_0000, 16'h0000, 0,  0, 16'h9999, 1,  1'b1, 16'h0000, 4'b0000, 16'h0000, 2'b11, 0};
    tbl[8]  = '{1'b1, 1'b0, 32'hFC00_0000, 16'h4321, 0,  0, 16'h0000, 1,  1'b1, 16'h0000, 4'b0000, 16'h4321, 2'b11, 0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0400_0000, 16'h0000, 20, 0, 16'h1111, 10, 1'b1, 16'h0000, 4'b0001, 16'h0000, 2'b11, 8};
    tbl[10] = '{1'b0, 1'b0, 32'h0800_0002, 16'h0000, 7,  0, 16'h2222, 10, 1'b0, 16'h2222, 4'b0010, 16'h0000, 2'b11, 8};
    tbl[11] = '{1'b1, 1'b0, 32'h0C00_0004, 16'h5555, 8,  0, 16'h0000, 10, 1'b1, 16'h0000, 4'b0100, 16'h5555, 2'b11, 8};
    tbl[12] = '{1'b0, 1'b0, 32'h1000_0006, 16'h0000, 0,  8, 16'h4444, 11, 1'b0, 16'h4444, 4'b1000, 16'h0000, 2'b11, 1};
    tbl[13] = '{1'b0, 1'b0, 32'h1000_0006, 16'h0000, 0,  9, 16'h4444, 11, 1'b1, 16'h0000, 4'b1000, 16'h0000, 2'b11, 1};
    tbl[14] = '{1'b0, 1'b0, 32'h0400_0010, 16'h0000, 0,  0, 16'hBEEF, 3,  1'b0, 16'hBEEF, 4'b0001, 16'h0000, 2'b11, 1};

    repeat (3) @(posedge main_clk);
    #1 check_reset_vals("por");
    @(negedge main_clk) reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      noise = i[0];
      run_vec(tbl[i], i);
    end

    // Reset while waiting for read data: nothing may come back afterwards.
    @(posedge main_clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h0800_0000; req_wdata = 16'h0;
    @(negedge main_clk);
    @(negedge main_clk);
    req_valid = 1'b0;
    check("rm issue ch_valid", 32'(ch_valid), 32'h2);
    ch_ready = 4'b0010;
    @(negedge main_clk);
    ch_ready = 4'h0;
    check("rm wait ch_valid", 32'(ch_valid), 32'h0);
    #1 reset = 1'b1;
    #1 check_reset_vals("rm");
    @(negedge main_clk) reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      ch_rvalid = 4'b0010; ch_rdata = {$urandom, $urandom};
      @(negedge main_clk);
      seen = seen | rsp_valid;
    end
    ch_rvalid = 4'h0;
    check("rm no response", 32'(seen), 32'd0);
    noise = 1'b0;
    run_vec(tbl[0], 100);

    for (int i = 0; i < 40; i++) begin
      rg = int'($urandom_range(0, 7));
      if (rg == 7) rg = 63;
      v.w  = 1'($urandom); v.b = 1'($urandom);
      v.a  = {6'(rg), 26'($urandom)};
      v.wd = 16'($urandom); v.rd = 16'($urandom);
      v.d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 2));
      v.r  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 2));
      v = model(v);
      noise = 1'($urandom);
      run_vec(v, 200 + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
